o_feature_writeback: RTL and testbench
======================================

// Module: o_feature_writeback
// PURPOSE
// Write-back engine: the write-side counterpart of the input feature fetcher. Accepts scaled CLP results
// (one word per cycle), packs them into 128-bit beats, buffers them and writes them to external feature
// memory from a decoder-issued (dst_addr, beat count) command. Pulses wb_done into the top-level fetch_done OR.
// PARAMETERS
// RESULT_WIDTH    32   width of one scaled_feature word (FEATURE_WIDTH + SCALER_WIDTH)
// DATA_BUS_WIDTH  128  external write bus width; LANES = DATA_BUS_WIDTH/RESULT_WIDTH = 4
// ADDR_WIDTH      16   external beat address width
// FIFO_DEPTH      4    packed-beat buffer depth (power of 2)
// PORTS
// clk              in   1    single clock, all logic rising-edge
// rst              in   1    reset, asynchronous, active-low
// wb_enable        in   1    one-cycle command strobe from instruction decoder
// wb_dst_addr      in   16   first external beat address
// wb_count         in   8    number of 128-bit beats to write
// feature_valid    in   1    scaled_feature word valid
// scaled_feature   in   32   result word
// feature_ready    out  1    word accepted when valid & ready
// o_data_bus_port  out  128  write data
// o_feature_addr   out  16   write address
// o_feature_wr_en  out  1    write request; transfer when wr_en & i_wr_ready
// i_wr_ready       in   1    external memory accepts the beat
// wb_busy          out  1    command in progress
// wb_done          out  1    one-cycle pulse after the last beat transfers
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, lane counter 0, FIFO empty, address/beat counters 0.
// - FSM: IDLE -> (wb_enable) RUN; RUN -> (all wb_count beats packed) DRAIN; DRAIN -> (FIFO empty, no write
//   pending) DONE; DONE -> IDLE after one cycle, wb_done=1 for exactly that cycle. wb_busy=1 in RUN/DRAIN/DONE.
// - wb_enable with wb_count==0: IDLE -> DONE directly; wb_done exactly 2 cycles after the strobe; no writes.
// - wb_enable while wb_busy: ignored, no effect on the running command.
// - feature_ready = (state==RUN) & !fifo_full. Not asserted in IDLE/DRAIN/DONE.
// - Packing: accepted word k of a beat goes to bits [32k+31:32k]; first word in lane 0.
//   Beat is pushed into the FIFO in the cycle after its 4th word is accepted. No partial beats.
// - Write side: FIFO head presented on o_data_bus_port with o_feature_wr_en=1 (registered), earliest the
//   cycle after the push. Data/address held stable until i_wr_ready; next beat may follow back-to-back.
// - o_feature_addr = wb_dst_addr + beats transferred so far, modulo 2^16 (0xFFFF wraps to 0x0000).
// - FIFO full: feature_ready drops; the pending 4th-lane push is never lost (push stalls the lane counter).
// - Simultaneous push and pop with FIFO full: the pop frees a slot next cycle; no same-cycle pass-through.
// - Asynchronous reset mid-command: everything aborts to reset state; buffered beats discarded, no wb_done.
// CONFIGURATION
// - WB_RELU_EN defined: each accepted word with MSB=1 (negative, two's complement) is written as 32'h0
//   before packing. Not defined: words are packed unmodified. No other behaviour differs.
// STRUCTURE
// - Shared header wb_defs.vh (alongside network_para.vh): FSM state encodings (IDLE/RUN/DRAIN/DONE),
//   LANES, default RESULT_WIDTH/DATA_BUS_WIDTH.
// - One sub-module: wb_beat_fifo (synchronous FIFO, DATA_BUS_WIDTH wide, FIFO_DEPTH deep, full/empty flags).
//   Packer, counters and FSM stay in o_feature_writeback.
// TESTING
// - dst=0x0010, count=2, 8 words 0x1..0x8, i_wr_ready=1 -> writes 0x0010:{4,3,2,1}, 0x0011:{8,7,6,5};
//   wb_done one cycle after the second transfer; wb_busy low after.
// - count=0 -> no o_feature_wr_en ever; wb_done 2 cycles after wb_enable; feature_ready stays 0.
// - i_wr_ready held 0, count=8, continuous valid -> FIFO fills after 16 words, feature_ready drops;
//   release ready -> all 8 beats written in order, addresses contiguous, no word lost or duplicated.
// - dst=0xFFFF, count=2 -> addresses 0xFFFF then 0x0000.
// - rst asserted mid-RUN after 2 beats accepted -> all outputs 0 immediately; new command afterwards
//   writes from its own dst_addr with clean lane alignment; no stale wb_done.
// - WB_RELU_EN defined, words 0xFFFFFFFF,5,0x80000000,7 -> beat {7,0,5,0}; undefined -> {7,0x80000000,5,0xFFFFFFFF}.

Source files
------------

// File: rtl/o_feature_writeback_pkg.sv
// Shared definitions for the feature write-back engine.
// Holds the default bus geometry and the FSM state encoding used by
// o_feature_writeback and its beat FIFO.
package o_feature_writeback_pkg;

  localparam int WB_RESULT_WIDTH   = 32;
  localparam int WB_DATA_BUS_WIDTH = 128;
  localparam int WB_ADDR_WIDTH     = 16;
  localparam int WB_COUNT_WIDTH    = 8;
  localparam int WB_FIFO_DEPTH     = 4;
  localparam int WB_LANES          = WB_DATA_BUS_WIDTH / WB_RESULT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_beat_fifo.sv
// wb_beat_fifo: synchronous FIFO of packed write beats.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; no pass-through.
// Ports: push_vld/push_dat write side, pop_rdy consumes head_dat, full/empty/count status.
module wb_beat_fifo
  import o_feature_writeback_pkg::*;
#(
  parameter int WIDTH = WB_DATA_BUS_WIDTH,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a pop never makes room
  // for a push in the same cycle.
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/o_feature_writeback.sv
// o_feature_writeback: packs scaled result words into bus beats and writes them to feature memory.
// Latency: beat pushed the cycle after its last word; offered on the write bus the cycle after the push.
// Backpressure: i_wr_ready low holds data/address; a full beat FIFO drops feature_ready.
// Ports: wb_enable/wb_dst_addr/wb_count command; feature_valid/scaled_feature/feature_ready input words;
//        o_data_bus_port/o_feature_addr/o_feature_wr_en/i_wr_ready write bus; wb_busy/wb_done status.
// Build option: define WB_RELU_EN to write negative words as zero.
module o_feature_writeback
  import o_feature_writeback_pkg::*;
#(
  parameter int RESULT_WIDTH   = WB_RESULT_WIDTH,
  parameter int DATA_BUS_WIDTH = WB_DATA_BUS_WIDTH,
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = WB_COUNT_WIDTH,
  parameter int FIFO_DEPTH     = WB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_enable,
  input  logic [ADDR_WIDTH-1:0]     wb_dst_addr,
  input  logic [COUNT_WIDTH-1:0]    wb_count,
  input  logic                      feature_valid,
  input  logic [RESULT_WIDTH-1:0]   scaled_feature,
  output logic                      feature_ready,
  output logic [DATA_BUS_WIDTH-1:0] o_data_bus_port,
  output logic [ADDR_WIDTH-1:0]     o_feature_addr,
  output logic                      o_feature_wr_en,
  input  logic                      i_wr_ready,
  output logic                      wb_busy,
  output logic                      wb_done
);

  localparam int LANES  = DATA_BUS_WIDTH / RESULT_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  wb_state_e                 state_q, state_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [DATA_BUS_WIDTH-1:0] beat_q, beat_d;
  logic                      push_pend_q, push_pend_d;
  logic [COUNT_WIDTH-1:0]    beats_left_q, beats_left_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [DATA_BUS_WIDTH-1:0] fifo_head;
  logic                      accept, last_lane;
  logic [RESULT_WIDTH-1:0]   word_in;

`ifdef WB_RELU_EN
  assign word_in = scaled_feature[RESULT_WIDTH-1] ? '0 : scaled_feature;
`else
  assign word_in = scaled_feature;
`endif

  assign feature_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept        = feature_valid && feature_ready;
  assign last_lane     = (lane_q == LANE_W'(LANES - 1));
  // A completed beat waits in beat_q until the FIFO has room; while it waits
  // the FIFO is full, so feature_ready is low and the lane counter cannot move.
  assign fifo_push     = push_pend_q && !fifo_full;
  assign fifo_pop      = !fifo_empty && i_wr_ready;

  wb_beat_fifo #(
    .WIDTH (DATA_BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (fifo_push),
    .push_dat (beat_q),
    .pop_rdy  (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    beat_d       = beat_q;
    push_pend_d  = push_pend_q;
    beats_left_d = beats_left_q;
    addr_d       = addr_q;

    if (fifo_push) begin
      push_pend_d = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_q == LANE_W'(i)) begin
          beat_d[i*RESULT_WIDTH +: RESULT_WIDTH] = word_in;
        end
      end
      if (last_lane) begin
        lane_d       = '0;
        push_pend_d  = 1'b1;
        beats_left_d = beats_left_q - COUNT_WIDTH'(1);
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end

    if (fifo_pop) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (wb_enable) begin
          addr_d       = wb_dst_addr;
          lane_d       = '0;
          beats_left_d = wb_count;
          state_d      = (wb_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && last_lane && (beats_left_q == COUNT_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the final beat's transfer completes, not a cycle later.
        if (!push_pend_q && (fifo_empty || ((fifo_cnt == CNT_W'(1)) && fifo_pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    // Registered from the DONE state, so the pulse lands the cycle after DONE.
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      beat_q       <= '0;
      push_pend_q  <= 1'b0;
      beats_left_q <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      beat_q       <= beat_d;
      push_pend_q  <= push_pend_d;
      beats_left_q <= beats_left_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_feature_wr_en = !fifo_empty;
  assign o_data_bus_port = fifo_empty ? '0 : fifo_head;
  assign o_feature_addr  = addr_q;
  assign wb_busy         = busy_q;
  assign wb_done         = done_q;

endmodule

// File: tb/tb_o_feature_writeback.sv
module tb_o_feature_writeback;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wb_enable = 1'b0;
  logic [15:0]  wb_dst_addr = '0;
  logic [7:0]   wb_count = '0;
  logic         feature_valid = 1'b0;
  logic [31:0]  scaled_feature = '0;
  logic         feature_ready;
  logic [127:0] o_data_bus_port;
  logic [15:0]  o_feature_addr;
  logic         o_feature_wr_en;
  logic         i_wr_ready = 1'b0;
  logic         wb_busy;
  logic         wb_done;

  o_feature_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .wb_enable       (wb_enable),
    .wb_dst_addr     (wb_dst_addr),
    .wb_count        (wb_count),
    .feature_valid   (feature_valid),
    .scaled_feature  (scaled_feature),
    .feature_ready   (feature_ready),
    .o_data_bus_port (o_data_bus_port),
    .o_feature_addr  (o_feature_addr),
    .o_feature_wr_en (o_feature_wr_en),
    .i_wr_ready      (i_wr_ready),
    .wb_busy         (wb_busy),
    .wb_done         (wb_done)
  );

  always #5 clk = ~clk;

`ifdef WB_RELU_EN
  localparam logic [127:0] RELU_EXP = 128'h00000007_00000000_00000005_00000000;
`else
  localparam logic [127:0] RELU_EXP = 128'h00000007_80000000_00000005_FFFFFFFF;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 1;   // 0: always ready, 1: never ready, 2: random

  // Reference model: accepted words collect into beats; each full beat gets
  // the next address after the command's destination.
  logic [31:0]  acc_words[$];
  logic [143:0] exp_q[$];
  logic [143:0] exp_beat;
  logic [15:0]  model_addr = '0;
  logic [31:0]  src[$];
  int           xfer_cnt = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0, acc_cnt = 0;
  logic [127:0] first_dat = '0;
  logic [15:0]  first_addr = '0, last_addr = '0;
  int           s1, s2, s_cyc, acc_before, cnt;
  logic [15:0]  dst;

  function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef WB_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_wr_ready = 1'b1;
      1:       i_wr_ready = 1'b0;
      default: i_wr_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (feature_valid && feature_ready) begin
        acc_words.push_back(ref_word(scaled_feature));
        acc_cnt++;
        if (acc_words.size() == 4) begin
          exp_q.push_back({model_addr, acc_words[3], acc_words[2], acc_words[1], acc_words[0]});
          model_addr = model_addr + 16'd1;
          acc_words.delete();
        end
      end
      if (o_feature_wr_en && i_wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 128'(o_feature_wr_en), 128'(0));
        end else begin
          exp_beat = exp_q.pop_front();
          chk("wr_addr", 128'(o_feature_addr), 128'(exp_beat[143:128]));
          chk("wr_data", o_data_bus_port, exp_beat[127:0]);
        end
        if (xfer_cnt == 0) begin
          first_dat  = o_data_bus_port;
          first_addr = o_feature_addr;
        end
        last_addr     = o_feature_addr;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      if (wb_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] d, input logic [7:0] c);
    model_addr  = d;
    xfer_cnt    = 0;
    done_cnt    = 0;
    wb_dst_addr = d;
    wb_count    = c;
    wb_enable   = 1'b1;
    tick();
    wb_enable   = 1'b0;
  endtask

  task automatic fill_src(input int n);
    src.delete();
    for (int k = 0; k < n; k++) src.push_back($urandom());
  endtask

  // Offer src[0..n-1] in order; returns how many were accepted within budget.
  task automatic send(input int n, input bit rnd, input int budget, output int sent);
    sent = 0;
    for (int k = 0; k < budget && sent < n; k++) begin
      feature_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      scaled_feature = src[sent];
      @(negedge clk);
      if (feature_valid && feature_ready) sent++;
      @(posedge clk);
      #1;
    end
    feature_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int beats);
    for (int k = 0; k < 500 && done_cnt == 0; k++) tick();
    tick();
    tick();
    chk("done_pulse_once", 128'(done_cnt), 128'(1));
    chk("xfer_count", 128'(xfer_cnt), 128'(beats));
    chk("model_drained", 128'(exp_q.size() + acc_words.size()), 128'(0));
    chk("busy_after_done", 128'(wb_busy), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 128'(o_feature_wr_en), 128'(0));
    chk("rst_addr", 128'(o_feature_addr), 128'(0));
    chk("rst_data", o_data_bus_port, 128'(0));
    chk("rst_busy", 128'(wb_busy), 128'(0));
    chk("rst_done", 128'(wb_done), 128'(0));
    chk("rst_ready", 128'(feature_ready), 128'(0));
    rst = 1'b1;
    tick();

    // Basic two-beat command with an always-ready memory.
    src.delete();
    for (int k = 0; k < 8; k++) src.push_back(32'(k + 1));
    rdy_mode = 0;
    issue(16'h0010, 8'd2);
    send(8, 1'b0, 100, s1);
    chk("basic_sent", 128'(s1), 128'(8));
    finish_cmd(2);
    chk("basic_first_addr", 128'(first_addr), 128'h10);
    chk("basic_first_data", first_dat, 128'h00000004_00000003_00000002_00000001);
    chk("basic_last_addr", 128'(last_addr), 128'h11);
    // done rises on the edge after the edge that completes the last transfer
    chk("basic_done_latency", 128'(done_cyc), 128'(last_xfer_cyc + 2));

    // Zero-beat command: no writes, done two cycles after the strobe.
    acc_before    = acc_cnt;
    feature_valid = 1'b1;
    s_cyc         = cyc;
    issue(16'h1234, 8'd0);
    repeat (5) tick();
    feature_valid = 1'b0;
    chk("zero_done_latency", 128'(done_cyc), 128'(s_cyc + 2));
    chk("zero_done_once", 128'(done_cnt), 128'(1));
    chk("zero_no_write", 128'(xfer_cnt), 128'(0));
    chk("zero_no_accept", 128'(acc_cnt), 128'(acc_before));

    // Backpressure: memory never ready while 8 beats are offered.
    // Four beats fill the FIFO; the fourth push happens the cycle after the
    // 16th word, so one more word lands in lane 0 before ready drops.
    rdy_mode = 1;
    fill_src(32);
    issue(16'($urandom()), 8'd8);
    send(32, 1'b0, 30, s1);
    chk("bp_ready_low", 128'(feature_ready), 128'(0));
    chk("bp_wr_en_held", 128'(o_feature_wr_en), 128'(1));
    chk("bp_no_xfer", 128'(xfer_cnt), 128'(0));
    chk("bp_words_before_stall", 128'(s1), 128'(17));
    src = src[s1:$];
    rdy_mode = 0;
    send(32 - s1, 1'b1, 400, s2);
    chk("bp_all_sent", 128'(s1 + s2), 128'(32));
    finish_cmd(8);

    // Address wrap at the top of the beat space, random ready.
    rdy_mode = 2;
    fill_src(8);
    issue(16'hFFFF, 8'd2);
    send(8, 1'b1, 200, s1);
    finish_cmd(2);
    chk("wrap_first_addr", 128'(first_addr), 128'hFFFF);
    chk("wrap_last_addr", 128'(last_addr), 128'h0000);

    // Negative-word handling.
    rdy_mode = 0;
    src.delete();
    src.push_back(32'hFFFFFFFF);
    src.push_back(32'h5);
    src.push_back(32'h80000000);
    src.push_back(32'h7);
    issue(16'h0040, 8'd1);
    send(4, 1'b0, 50, s1);
    finish_cmd(1);
    chk("relu_beat", first_dat, RELU_EXP);

    // Reset mid-command after two beats and one extra word.
    rdy_mode = 1;
    fill_src(9);
    issue(16'h0300, 8'd4);
    send(9, 1'b0, 40, s1);
    chk("mid_sent", 128'(s1), 128'(9));
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", 128'(o_feature_wr_en), 128'(0));
    chk("mid_rst_busy", 128'(wb_busy), 128'(0));
    chk("mid_rst_ready", 128'(feature_ready), 128'(0));
    chk("mid_rst_addr", 128'(o_feature_addr), 128'(0));
    chk("mid_rst_data", o_data_bus_port, 128'(0));
    chk("mid_rst_done", 128'(wb_done), 128'(0));
    acc_words.delete();
    exp_q.delete();
    xfer_cnt = 0;
    done_cnt = 0;
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("no_stale_done", 128'(done_cnt), 128'(0));
    rdy_mode = 2;
    fill_src(8);
    issue(16'h0200, 8'd2);
    send(8, 1'b1, 200, s1);
    finish_cmd(2);
    chk("post_rst_first_addr", 128'(first_addr), 128'h0200);

    // Random commands, each with an ignored strobe while busy.
    for (int it = 0; it < 4; it++) begin
      rdy_mode = 2;
      cnt = $urandom_range(1, 5);
      dst = 16'($urandom());
      fill_src(4 * cnt);
      issue(dst, 8'(cnt));
      send(2, 1'b1, 100, s1);
      wb_dst_addr = ~dst;
      wb_count    = 8'(cnt + 3);
      wb_enable   = 1'b1;
      tick();
      wb_enable   = 1'b0;
      src = src[s1:$];
      send(4 * cnt - s1, 1'b1, 400, s2);
      chk("rand_all_sent", 128'(s1 + s2), 128'(4 * cnt));
      finish_cmd(cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
